// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Types and constants shared by the cache tag/state engine:
//   u16/u32/u64    - plain unsigned vector typedefs
//   READ/WRITE     - encoding of the request rw bit
//   state_t        - controller states (IDLE, LOOKUP, FLUSH)
//   line_t         - per-line state {valid, dirty, tag}. The tag field is 32 bits
//                    wide and holds the zero-extended tag, so the same struct
//                    works for every address split with a tag of 32 bits or less.
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef logic [15:0] u16;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic dirty;
        u32   tag;
    } line_t;

endpackage

// File: rtl/cache_lru_set.sv
// -----------------------------------------------------------------------------
// cache_lru_set
// True-LRU bookkeeping for one set. Purely combinational.
// The ages of a set always form a permutation of 0..ASSOC-1 (age ASSOC-1 = LRU).
//
// Ports:
//   ages        in   packed ages of the set, way w at [w*WAY_W +: WAY_W]
//   valid       in   valid bit per way
//   hit         in   lookup hit
//   hit_way     in   way that hit (ignored on a miss)
//   victim_way  out  lowest-index invalid way, else the LRU way
//   access_way  out  way being touched: hit_way on a hit, victim_way on a miss
//   ages_next   out  ages after the access (accessed way -> 0, younger ways +1)
// -----------------------------------------------------------------------------
module cache_lru_set
    import cache_pkg::*;
#(
    parameter  int ASSOC = 2,
    localparam int WAY_W = $clog2(ASSOC)
) (
    input  logic [ASSOC*WAY_W-1:0] ages,
    input  logic [ASSOC-1:0]       valid,
    input  logic                   hit,
    input  logic [WAY_W-1:0]       hit_way,
    output logic [WAY_W-1:0]       victim_way,
    output logic [WAY_W-1:0]       access_way,
    output logic [ASSOC*WAY_W-1:0] ages_next
);

    logic [WAY_W-1:0] age [ASSOC];
    logic [WAY_W-1:0] old_age;
    logic             found;

    genvar gi;
    generate
        for (gi = 0; gi < ASSOC; gi++) begin : g_age
            assign age[gi] = ages[gi*WAY_W +: WAY_W];
            // Only ways younger than the accessed one age by one; this keeps the
            // set a permutation whether the access was a hit or a fill.
            assign ages_next[gi*WAY_W +: WAY_W] =
                (access_way == WAY_W'(gi)) ? '0 :
                (age[gi] < old_age)        ? age[gi] + 1'b1 :
                                             age[gi];
        end
    endgenerate

    // Fill empty ways first (lowest index wins), only then replace the LRU line.
    always_comb begin
        victim_way = '0;
        found      = 1'b0;
        for (int w = 0; w < ASSOC; w++) begin
            if (!valid[w] && !found) begin
                victim_way = WAY_W'(w);
                found      = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < ASSOC; w++) begin
                if (age[w] == WAY_W'(ASSOC - 1)) begin
                    victim_way = WAY_W'(w);
                end
            end
        end
    end

    assign access_way = hit ? hit_way : victim_way;
    assign old_age    = age[access_way];

endmodule

// File: rtl/cache_model.sv
// -----------------------------------------------------------------------------
// cache_model
// Set-associative cache tag/state engine: hit/miss, true-LRU replacement,
// write-back/write-allocate dirty tracking and a whole-cache flush.
//
// Build option: define CACHE_STATS_EN to build the saturating statistics
// counters; without it every cnt_* output is tied to 0.
//
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   req_valid/req_ready        request handshake (rw: 0 read, 1 write; address)
//   flush_req                  start a flush (wins over a same-cycle request)
//   flush_busy/flush_done      flush in progress / one-cycle end pulse
//   rsp_valid                  one-cycle result strobe, the cycle after lookup
//   rsp_hit/evict/writeback    access result flags (held until next response)
//   rsp_way, rsp_victim_tag    way hit or filled, tag of evicted line (0 if none)
//   cnt_*                      statistics counters
//
// Timing: request accepted on edge k, LOOKUP during the following cycle,
// result and counters registered on edge k+1, controller back in IDLE.
// -----------------------------------------------------------------------------
module cache_model #(
    parameter int SETS         = 16,
    parameter int ASSOC        = 2,
    parameter int LINESIZE     = 16,
    parameter int ADDRESS_SIZE = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    rw,
    input  logic [ADDRESS_SIZE-1:0] address,
    input  logic                    flush_req,
    output logic                    flush_busy,
    output logic                    flush_done,
    output logic                    rsp_valid,
    output logic                    rsp_hit,
    output logic                    rsp_evict,
    output logic                    rsp_writeback,
    output logic [$clog2(ASSOC)-1:0] rsp_way,
    output logic [ADDRESS_SIZE-$clog2(LINESIZE)-$clog2(SETS)-1:0] rsp_victim_tag,
    output logic [CNT_WIDTH-1:0]    cnt_accesses,
    output logic [CNT_WIDTH-1:0]    cnt_reads,
    output logic [CNT_WIDTH-1:0]    cnt_writes,
    output logic [CNT_WIDTH-1:0]    cnt_hits,
    output logic [CNT_WIDTH-1:0]    cnt_misses,
    output logic [CNT_WIDTH-1:0]    cnt_evictions,
    output logic [CNT_WIDTH-1:0]    cnt_writebacks
);
    import cache_pkg::*;

    localparam int OFF_W = $clog2(LINESIZE);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(ASSOC);
    localparam int TAG_W = ADDRESS_SIZE - OFF_W - IDX_W;

    // Controller
    state_t state_reg, state_next;
    logic   accept;

    // Captured request
    logic             rw_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [TAG_W-1:0] tag_reg;

    // Address split of the incoming request
    logic [IDX_W-1:0] addr_idx;
    logic [TAG_W-1:0] addr_tag;
    logic             addr_unused;

    // Line state. valid/dirty/age need reset so they live in flops; tags are only
    // meaningful under valid and sit in per-way RAM arrays.
    logic [ASSOC-1:0]       valid_reg [SETS];
    logic [ASSOC-1:0]       dirty_reg [SETS];
    logic [ASSOC*WAY_W-1:0] age_reg   [SETS];

    // Lookup datapath
    line_t                  cur_line [ASSOC];
    line_t                  victim_line;
    logic [ASSOC-1:0]       hit_vec;
    logic                   hit;
    logic [WAY_W-1:0]       hit_way;
    logic [WAY_W-1:0]       victim_way;
    logic [WAY_W-1:0]       fill_way;
    logic [ASSOC*WAY_W-1:0] ages_next;
    logic                   evict;
    logic                   writeback;
    logic [TAG_W-1:0]       victim_tag;
    logic                   tag_we;

    // Flush walker: {set, way}, way in the low bits so each set is finished in turn
    logic [IDX_W+WAY_W-1:0] flush_idx_reg;
    logic [IDX_W-1:0]       flush_set;
    logic [WAY_W-1:0]       flush_way;
    logic                   flush_last;

    // Response registers
    logic             rsp_valid_reg;
    logic             rsp_hit_reg;
    logic             rsp_evict_reg;
    logic             rsp_writeback_reg;
    logic [WAY_W-1:0] rsp_way_reg;
    logic [TAG_W-1:0] rsp_victim_tag_reg;

    assign addr_tag    = address[ADDRESS_SIZE-1 -: TAG_W];
    assign addr_idx    = address[OFF_W +: IDX_W];
    // Byte offset does not take part in tag/state tracking.
    assign addr_unused = ^address[OFF_W-1:0];

    assign flush_set  = flush_idx_reg[IDX_W+WAY_W-1:WAY_W];
    assign flush_way  = flush_idx_reg[WAY_W-1:0];
    assign flush_last = &flush_idx_reg;

    // ------------------------------------------------------------------
    // Per-way tag RAM with registered read. The read is launched on the
    // accept edge, so the tags of the indexed set are ready during LOOKUP.
    // Writes only happen on the LOOKUP edge, never on an accept edge.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ASSOC; gi++) begin : g_way
            logic [TAG_W-1:0] tag_mem [SETS];
            logic [TAG_W-1:0] tag_rd_reg;

            always_ff @(posedge clk) begin
                if (tag_we && (fill_way == WAY_W'(gi))) begin
                    tag_mem[idx_reg] <= tag_reg;
                end
                if (accept) begin
                    tag_rd_reg <= tag_mem[addr_idx];
                end
            end

            assign cur_line[gi] = '{valid: valid_reg[idx_reg][gi],
                                    dirty: dirty_reg[idx_reg][gi],
                                    tag:   32'(tag_rd_reg)};
            assign hit_vec[gi]  = cur_line[gi].valid && (cur_line[gi].tag == 32'(tag_reg));
        end
    endgenerate

    assign hit = |hit_vec;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
        end
    end

    cache_lru_set #(
        .ASSOC(ASSOC)
    ) u_lru (
        .ages       (age_reg[idx_reg]),
        .valid      (valid_reg[idx_reg]),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way),
        .access_way (fill_way),
        .ages_next  (ages_next)
    );

    assign victim_line = cur_line[victim_way];
    assign evict       = !hit && victim_line.valid;
    assign writeback   = evict && victim_line.dirty;
    assign victim_tag  = evict ? victim_line.tag[TAG_W-1:0] : '0;
    assign tag_we      = (state_reg == LOOKUP) && !hit;

    // ------------------------------------------------------------------
    // Next-state / handshake
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        req_ready  = 1'b0;
        flush_busy = 1'b0;
        flush_done = 1'b0;
        case (state_reg)
            IDLE: begin
                // A pending flush masks ready so a same-cycle request is never
                // seen as handshaken.
                if (flush_req) begin
                    state_next = FLUSH;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        accept     = 1'b1;
                        state_next = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                state_next = IDLE;
            end
            FLUSH: begin
                flush_busy = 1'b1;
                if (flush_last) begin
                    flush_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, line state and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg          <= IDLE;
            rw_reg             <= READ;
            idx_reg            <= '0;
            tag_reg            <= '0;
            flush_idx_reg      <= '0;
            rsp_valid_reg      <= 1'b0;
            rsp_hit_reg        <= 1'b0;
            rsp_evict_reg      <= 1'b0;
            rsp_writeback_reg  <= 1'b0;
            rsp_way_reg        <= '0;
            rsp_victim_tag_reg <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                dirty_reg[s] <= '0;
                for (int w = 0; w < ASSOC; w++) begin
                    age_reg[s][w*WAY_W +: WAY_W] <= WAY_W'(w);
                end
            end
        end else begin
            state_reg     <= state_next;
            rsp_valid_reg <= 1'b0;

            if (accept) begin
                rw_reg  <= rw;
                idx_reg <= addr_idx;
                tag_reg <= addr_tag;
            end

            if (state_reg == IDLE) begin
                flush_idx_reg <= '0;
            end

            if (state_reg == LOOKUP) begin
                rsp_valid_reg      <= 1'b1;
                rsp_hit_reg        <= hit;
                rsp_evict_reg      <= evict;
                rsp_writeback_reg  <= writeback;
                rsp_way_reg        <= fill_way;
                rsp_victim_tag_reg <= victim_tag;
                age_reg[idx_reg]   <= ages_next;
                valid_reg[idx_reg][fill_way] <= 1'b1;
                if (hit) begin
                    if (rw_reg == WRITE) begin
                        dirty_reg[idx_reg][fill_way] <= 1'b1;
                    end
                end else begin
                    // Write-allocate: a write miss fills the line already dirty.
                    dirty_reg[idx_reg][fill_way] <= (rw_reg == WRITE);
                end
            end

            if (state_reg == FLUSH) begin
                // Ages are left as they are; only the line contents go away.
                valid_reg[flush_set][flush_way] <= 1'b0;
                dirty_reg[flush_set][flush_way] <= 1'b0;
                flush_idx_reg <= flush_idx_reg + 1'b1;
            end
        end
    end

    assign rsp_valid      = rsp_valid_reg;
    assign rsp_hit        = rsp_hit_reg;
    assign rsp_evict      = rsp_evict_reg;
    assign rsp_writeback  = rsp_writeback_reg;
    assign rsp_way        = rsp_way_reg;
    assign rsp_victim_tag = rsp_victim_tag_reg;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef CACHE_STATS_EN
    logic [CNT_WIDTH-1:0] acc_reg, rd_reg, wr_reg, hits_reg, miss_reg, ev_reg, wb_reg;
    logic                 lookup_active;
    logic                 flush_wb;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign lookup_active = (state_reg == LOOKUP);
    assign flush_wb      = (state_reg == FLUSH) &&
                           valid_reg[flush_set][flush_way] &&
                           dirty_reg[flush_set][flush_way];

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_reg  <= '0;
            rd_reg   <= '0;
            wr_reg   <= '0;
            hits_reg <= '0;
            miss_reg <= '0;
            ev_reg   <= '0;
            wb_reg   <= '0;
        end else begin
            if (lookup_active) begin
                acc_reg <= sat_inc(acc_reg);
                if (rw_reg == READ) begin
                    rd_reg <= sat_inc(rd_reg);
                end else begin
                    wr_reg <= sat_inc(wr_reg);
                end
                if (hit) begin
                    hits_reg <= sat_inc(hits_reg);
                end else begin
                    miss_reg <= sat_inc(miss_reg);
                end
                if (evict) begin
                    ev_reg <= sat_inc(ev_reg);
                end
            end
            // Lookup and flush never overlap, so one increment per cycle suffices.
            if ((lookup_active && writeback) || flush_wb) begin
                wb_reg <= sat_inc(wb_reg);
            end
        end
    end

    assign cnt_accesses   = acc_reg;
    assign cnt_reads      = rd_reg;
    assign cnt_writes     = wr_reg;
    assign cnt_hits       = hits_reg;
    assign cnt_misses     = miss_reg;
    assign cnt_evictions  = ev_reg;
    assign cnt_writebacks = wb_reg;
`else
    assign cnt_accesses   = '0;
    assign cnt_reads      = '0;
    assign cnt_writes     = '0;
    assign cnt_hits       = '0;
    assign cnt_misses     = '0;
    assign cnt_evictions  = '0;
    assign cnt_writebacks = '0;
`endif

endmodule

// File: tb/tb_cache_model.sv
// -----------------------------------------------------------------------------
// tb_cache_model
// Self-checking bench for cache_model with default geometry (offset 4, index 4,
// tag 8). A behavioural cache model computes the expected response of every
// request; the expectation is queued when the request is driven and compared
// when rsp_valid appears. A second instance with CNT_WIDTH = 4 sees the same
// traffic and is used for the saturation check. Counter expectations follow
// the CACHE_STATS_EN build option.
// -----------------------------------------------------------------------------
module tb_cache_model;
    import cache_pkg::*;

    localparam int SETS  = 16;
    localparam int ASSOC = 2;
    localparam int LSZ   = 16;
    localparam int AW    = 16;
    localparam int CW    = 32;
    localparam int WAY_W = 1;
    localparam int TAG_W = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          rw = 1'b0;
    logic [AW-1:0] address = '0;
    logic          flush_req = 1'b0;

    logic             req_ready, flush_busy, flush_done;
    logic             rsp_valid, rsp_hit, rsp_evict, rsp_writeback;
    logic [WAY_W-1:0] rsp_way;
    logic [TAG_W-1:0] rsp_victim_tag;
    logic [CW-1:0]    cnt_accesses, cnt_reads, cnt_writes, cnt_hits;
    logic [CW-1:0]    cnt_misses, cnt_evictions, cnt_writebacks;

    logic             d4_req_ready, d4_flush_busy, d4_flush_done;
    logic             d4_rsp_valid, d4_rsp_hit, d4_rsp_evict, d4_rsp_writeback;
    logic [WAY_W-1:0] d4_rsp_way;
    logic [TAG_W-1:0] d4_rsp_victim_tag;
    logic [3:0]       d4_acc, d4_rd, d4_wr, d4_hits, d4_miss, d4_ev, d4_wb;

    always #5 clk = ~clk;

    cache_model #(
        .SETS(SETS), .ASSOC(ASSOC), .LINESIZE(LSZ), .ADDRESS_SIZE(AW), .CNT_WIDTH(CW)
    ) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .rw(rw), .address(address), .flush_req(flush_req),
        .flush_busy(flush_busy), .flush_done(flush_done),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_evict(rsp_evict),
        .rsp_writeback(rsp_writeback), .rsp_way(rsp_way), .rsp_victim_tag(rsp_victim_tag),
        .cnt_accesses(cnt_accesses), .cnt_reads(cnt_reads), .cnt_writes(cnt_writes),
        .cnt_hits(cnt_hits), .cnt_misses(cnt_misses), .cnt_evictions(cnt_evictions),
        .cnt_writebacks(cnt_writebacks)
    );

    cache_model #(
        .SETS(SETS), .ASSOC(ASSOC), .LINESIZE(LSZ), .ADDRESS_SIZE(AW), .CNT_WIDTH(4)
    ) u_dut4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d4_req_ready),
        .rw(rw), .address(address), .flush_req(flush_req),
        .flush_busy(d4_flush_busy), .flush_done(d4_flush_done),
        .rsp_valid(d4_rsp_valid), .rsp_hit(d4_rsp_hit), .rsp_evict(d4_rsp_evict),
        .rsp_writeback(d4_rsp_writeback), .rsp_way(d4_rsp_way),
        .rsp_victim_tag(d4_rsp_victim_tag),
        .cnt_accesses(d4_acc), .cnt_reads(d4_rd), .cnt_writes(d4_wr),
        .cnt_hits(d4_hits), .cnt_misses(d4_miss), .cnt_evictions(d4_ev),
        .cnt_writebacks(d4_wb)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected counter value for the current build.
    function automatic logic [63:0] ec(input logic [63:0] v);
`ifdef CACHE_STATS_EN
        return v;
`else
        return 64'(0 * v);
`endif
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic             hit;
        logic             evict;
        logic             wb;
        logic [WAY_W-1:0] way;
        logic [TAG_W-1:0] vtag;
        logic [31:0]      acc, rd, wr, hits, miss, ev, wbs;
    } exp_t;

    exp_t sb[$];

    logic             m_valid [SETS][ASSOC];
    logic             m_dirty [SETS][ASSOC];
    logic [TAG_W-1:0] m_tag   [SETS][ASSOC];
    int               m_age   [SETS][ASSOC];
    logic [31:0]      m_acc, m_rd, m_wr, m_hit, m_miss, m_ev, m_wb;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < ASSOC; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = '0;
                m_age[s][w]   = w;
            end
        end
        m_acc = 0; m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0; m_ev = 0; m_wb = 0;
    endtask

    task automatic model_access(input logic r, input logic [AW-1:0] a, output exp_t e);
        int idx = int'(a[7:4]);
        logic [TAG_W-1:0] tg = a[15:8];
        int way = -1;
        int old;
        e = '0;
        for (int w = 0; w < ASSOC; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tg) way = w;
        if (way >= 0) begin
            e.hit = 1'b1;
            if (r) m_dirty[idx][way] = 1'b1;
        end else begin
            for (int w = 0; w < ASSOC; w++)
                if (!m_valid[idx][w] && way < 0) way = w;
            if (way < 0)
                for (int w = 0; w < ASSOC; w++)
                    if (m_age[idx][w] == ASSOC - 1) way = w;
            e.evict = m_valid[idx][way];
            e.wb    = m_valid[idx][way] && m_dirty[idx][way];
            e.vtag  = e.evict ? m_tag[idx][way] : '0;
            m_valid[idx][way] = 1'b1;
            m_dirty[idx][way] = r;
            m_tag[idx][way]   = tg;
        end
        old = m_age[idx][way];
        for (int w = 0; w < ASSOC; w++)
            if (m_age[idx][w] < old) m_age[idx][w]++;
        m_age[idx][way] = 0;
        e.way = WAY_W'(way);
        m_acc++;
        if (r) m_wr++; else m_rd++;
        if (e.hit) m_hit++; else m_miss++;
        if (e.evict) m_ev++;
        if (e.wb) m_wb++;
        e.acc = m_acc; e.rd = m_rd; e.wr = m_wr; e.hits = m_hit;
        e.miss = m_miss; e.ev = m_ev; e.wbs = m_wb;
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < ASSOC; w++) begin
                if (m_valid[s][w] && m_dirty[s][w]) m_wb++;
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
    endtask

    // ---------------- response monitor ----------------
    int rsp_n = 0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                rsp_n++;
                $display("rsp %0d: hit=%0d evict=%0d wb=%0d way=%0d vtag=0x%02h acc=%0d",
                         rsp_n, rsp_hit, rsp_evict, rsp_writeback, rsp_way,
                         rsp_victim_tag, cnt_accesses);
                chk("sb_hit",       rsp_hit,        e.hit);
                chk("sb_evict",     rsp_evict,      e.evict);
                chk("sb_writeback", rsp_writeback,  e.wb);
                chk("sb_way",       rsp_way,        e.way);
                chk("sb_vtag",      rsp_victim_tag, e.vtag);
                chk("sb_cnt_acc",   cnt_accesses,   ec(e.acc));
                chk("sb_cnt_rd",    cnt_reads,      ec(e.rd));
                chk("sb_cnt_wr",    cnt_writes,     ec(e.wr));
                chk("sb_cnt_hit",   cnt_hits,       ec(e.hits));
                chk("sb_cnt_miss",  cnt_misses,     ec(e.miss));
                chk("sb_cnt_ev",    cnt_evictions,  ec(e.ev));
                chk("sb_cnt_wb",    cnt_writebacks, ec(e.wbs));
            end
        end
    end

    // ---------------- stimulus tasks (entered/left at posedge + 1) ----------------
    task automatic do_reset();
        reset = 1'b0;
        req_valid = 1'b0;
        flush_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic do_access(input logic r, input logic [AW-1:0] a);
        exp_t e;
        int n = 0;
        req_valid = 1'b1;
        rw = r;
        address = a;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        model_access(r, a, e);
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("lookup_not_ready", req_ready, 0);
        @(posedge clk); #1;
        chk("rsp_latency", rsp_valid, 1);
    endtask

    task automatic do_flush();
        int busy = 0, done = 0, done_at = -1, ready_bad = 0, n = 0;
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        while (flush_busy && n < 1000) begin
            busy++;
            if (req_ready) ready_bad++;
            if (flush_done) begin
                done++;
                done_at = busy;
            end
            @(posedge clk); #1;
            n++;
        end
        model_flush();
        $display("flush: busy=%0d done=%0d wb=%0d", busy, done, cnt_writebacks);
        chk("flush_busy_cycles", busy, SETS * ASSOC);
        chk("flush_done_count", done, 1);
        chk("flush_done_last", done_at, SETS * ASSOC);
        chk("flush_ready_low", ready_bad, 0);
        chk("flush_wb_cnt", cnt_writebacks, ec(m_wb));
    endtask

    // ---------------- main sequence ----------------
    logic [7:0] tags [4];

    initial begin
        tags[0] = 8'h11; tags[1] = 8'h22; tags[2] = 8'h33; tags[3] = 8'h44;
        model_reset();
        do_reset();

        // Reset state
        chk("rst_ready",     req_ready, 1);
        chk("rst_busy",      flush_busy, 0);
        chk("rst_done",      flush_done, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_fields", {rsp_hit, rsp_evict, rsp_writeback, rsp_way, rsp_victim_tag}, 0);
        chk("rst_cnt_acc",   cnt_accesses, 0);

        // Miss then hit in the same line
        do_access(READ, 16'h1234);
        chk("t1_first_hit", rsp_hit, 0);
        chk("t1_first_way", rsp_way, 0);
        do_access(READ, 16'h1238);
        chk("t1_second_hit", rsp_hit, 1);
        chk("t1_cnt_acc",  cnt_accesses, ec(2));
        chk("t1_cnt_hits", cnt_hits, ec(1));
        chk("t1_cnt_miss", cnt_misses, ec(1));

        // LRU victim selection
        do_reset();
        do_access(READ, 16'h1230);
        do_access(READ, 16'h3430);
        do_access(READ, 16'h1230);
        do_access(READ, 16'h5630);
        chk("t2_hit",   rsp_hit, 0);
        chk("t2_evict", rsp_evict, 1);
        chk("t2_vtag",  rsp_victim_tag, 8'h34);
        chk("t2_way",   rsp_way, 1);
        chk("t2_wb",    rsp_writeback, 0);

        // Dirty eviction
        do_reset();
        do_access(WRITE, 16'h7000);
        do_access(WRITE, 16'h8000);
        do_access(READ,  16'h9000);
        chk("t3_evict", rsp_evict, 1);
        chk("t3_wb",    rsp_writeback, 1);
        chk("t3_vtag",  rsp_victim_tag, 8'h70);
        chk("t3_cnt_wb", cnt_writebacks, ec(1));

        // Flush of two dirty lines
        do_reset();
        do_access(WRITE, 16'hA010);
        do_access(WRITE, 16'hB020);
        do_flush();
        chk("t4_cnt_wb", cnt_writebacks, ec(2));
        do_access(READ, 16'hA010);
        chk("t4_reread_hit",   rsp_hit, 0);
        chk("t4_reread_evict", rsp_evict, 0);

        // Flush and request in the same cycle: flush first, request afterwards
        req_valid = 1'b1;
        rw = READ;
        address = 16'hB020;
        do_flush();
        chk("t5_idle_ready", req_ready, 1);
        do_access(READ, 16'hB020);
        chk("t5_hit",   rsp_hit, 0);
        chk("t5_evict", rsp_evict, 0);

        // Reset in the middle of a flush
        do_access(WRITE, 16'hC040);
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("t6_busy_before", flush_busy, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        chk("t6_busy",   flush_busy, 0);
        chk("t6_ready",  req_ready, 1);
        chk("t6_done",   flush_done, 0);
        chk("t6_cnt_acc", cnt_accesses, 0);
        chk("t6_cnt_wb",  cnt_writebacks, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("t6_no_done", flush_done, 0);
        end

        // Random traffic over a few sets and tags, with periodic flushes
        for (int i = 0; i < 150; i++) begin
            logic [AW-1:0] a;
            a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            do_access(1'($urandom_range(0, 1)), a);
            if (i % 50 == 49) do_flush();
        end

        // Counter saturation on the 4-bit instance
        do_reset();
        for (int i = 0; i < 20; i++) do_access(READ, 16'h0100);
        chk("sat_cnt_acc32", cnt_accesses, ec(20));
        chk("sat_cnt_acc4",  d4_acc, ec(15));

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_model.md
# cache_model

Parametrised set-associative cache tag/state engine: the synthesizable successor of the trace-driven cache simulator. It accepts one read/write address per request over a valid/ready handshake and models hit/miss, true-LRU replacement, write-back/write-allocate dirty tracking, and a full-cache flush. It reports a per-access result and optional saturating statistics counters. It sits between the trace-reader bench or stimulus front end and the statistics/report logic.

## Interface
- SETS, 16, number of sets; power of two, ≥2
- ASSOC, 2, ways per set; power of two, ≥2
- LINESIZE, 16, bytes per line; power of two, ≥2
- ADDRESS_SIZE, 16, address width in bits
- CNT_WIDTH, 32, statistics counter width
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request can be accepted
- rw  input  1  0 = read, 1 = write
- address  input  ADDRESS_SIZE  byte address
- flush_req  input  1  start flush of whole cache
- flush_busy  output  1  flush in progress
- flush_done  output  1  one-cycle pulse at flush end
- rsp_valid  output  1  one-cycle result strobe
- rsp_hit  output  1  access hit
- rsp_evict  output  1  valid line replaced
- rsp_writeback  output  1  replaced line was dirty
- rsp_way  output  log2(ASSOC)  way hit or filled
- rsp_victim_tag  output  tagWidth  tag of evicted line (0 if none)
- cnt_accesses, cnt_reads, cnt_writes, cnt_hits, cnt_misses, cnt_evictions, cnt_writebacks  output  CNT_WIDTH each  statistics

## Operation
- Address split: bsWidth = log2(LINESIZE) offset bits; indexWidth = log2(SETS) index bits; tagWidth = ADDRESS_SIZE − bsWidth − indexWidth upper bits.
- Per line: valid, dirty, tag, age (log2(ASSOC) bits). Ages within a set are always a permutation of 0..ASSOC−1; age ASSOC−1 = LRU.
- Reset: all valid/dirty = 0, age of way w = w, counters = 0, FSM = IDLE.
- FSM IDLE: req_ready = 1. flush_req has priority over req_valid when both are high, so a simultaneous request is not accepted. flush_req → FLUSH; handshake (req_valid & req_ready) → LOOKUP with rw/address captured.
- LOOKUP: tag compare across ways.
  - Hit: write hit sets dirty.
  - Miss: victim = lowest-index invalid way, else the LRU way. Evict if victim valid; writeback if victim dirty. Fill tag, valid = 1, dirty = rw.
  - Accessed way age → 0; ways with age < old age increment. Result registered → IDLE.
- FLUSH: index counter walks set 0..SETS−1, way 0..ASSOC−1, one line per cycle. Each valid dirty line counts one writeback. Each line is invalidated (ages untouched). The last line raises flush_done for one cycle → IDLE.
- Counters: accesses/reads/writes/hits/misses per request, evictions/writebacks per miss; flush writebacks add to cnt_writebacks only. All saturate at 2^CNT_WIDTH−1.
- Reset asserted in any state (including mid-flush or mid-lookup): the in-flight operation is discarded, and no rsp_valid or flush_done is issued for it.

## Timing
- Accept on edge k; result registered on edge k+1; rsp_valid is high for the cycle after edge k+1. That cycle is IDLE, so a new request may be accepted in it. Maximum throughput is one access per 2 cycles.
- rsp_* fields hold their value until the next response. All are 0 after reset.
- Counters update on the same edge as the result registers.
- flush_busy is high from the edge after flush_req through the last line cycle: exactly SETS·ASSOC cycles. flush_done coincides with the last busy cycle. req_ready is 0 throughout.
- All outputs are 0 after reset except req_ready = 1.

## Configuration
- CACHE_STATS_EN defined: counters are built and driven as above.
- CACHE_STATS_EN undefined: no counter flops exist; all cnt_* outputs are tied to 0. Results and flush behaviour are unchanged.

## Structure
- Shared package cache_pkg: u16/u32/u64 typedefs, rw encoding constants (READ = 0, WRITE = 1), FSM state enum (IDLE, LOOKUP, FLUSH), and a line-state struct {valid, dirty, tag}.
- Sub-module cache_lru_set: per-set age update (access way in, victim way out), instantiated once on the indexed set.

## Test plan
All tests use defaults: offset 4, index 4, tag 8.
- Reset, read 0x1234 → rsp_hit = 0, evict = 0, way 0; read 0x1238 → hit, way 0; accesses = 2, hits = 1, misses = 1.
- Reads 0x1230, 0x3430, 0x1230, then 0x5630 → last access misses, evict = 1, rsp_victim_tag = 0x34, way 1, writeback = 0.
- Writes 0x7000, 0x8000, then read 0x9000 → evict = 1, writeback = 1, rsp_victim_tag = 0x70, cnt_writebacks = 1.
- Two dirty lines, then pulse flush_req → flush_busy 32 cycles, single flush_done, cnt_writebacks += 2; re-reading either address misses with evict = 0.
- flush_req and req_valid in the same cycle → flush taken, req_ready = 0 for 32 cycles, then the request is accepted and answered 2 cycles later.
- Reset low at flush cycle 10 → next cycle flush_busy = 0, req_ready = 1, counters 0, no flush_done. Separately, with CNT_WIDTH = 4, 20 reads → cnt_accesses = 15.
